// File: rtl/pipelined_arith_unit.sv
`default_nettype none
// =============================================================================
// pipelined_arith_unit : ADD/SUB/ADC/SBB over STAGES carry-ripple slices, one slice per stage
// Revision 1.0
// =============================================================================
module pipelined_arith_unit #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_overflow,
   output logic             out_zero,
   output logic             out_negative
);
   localparam int c_SLICE_W = WIDTH / STAGES;

   if (WIDTH < 4 || WIDTH > 64 || STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0) begin : g_param_check
      $fatal(1, "pipelined_arith_unit: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
   end

   logic             w_advance;
   logic             w_sub;
   logic             w_cin0;
   logic [WIDTH-1:0] w_b_eff;

   assign w_advance = ~out_valid | out_ready;
   assign in_ready  = w_advance;

   // Subtraction is A + ~B + 1 (SUB) or A + ~B + ~cin (SBB); the final carry is inverted into a borrow.
   assign w_sub   = in_op[0];
   assign w_cin0  = in_op[0] ^ (in_op[1] & in_cin);
   assign w_b_eff = w_sub ? ~in_b : in_b;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int c_REM_W  = WIDTH - s * c_SLICE_W;
      localparam int c_DONE_W = (s + 1) * c_SLICE_W;

      logic                w_valid_i;
      logic [c_REM_W-1:0]  w_a_i;
      logic [c_REM_W-1:0]  w_b_i;
      logic                w_cy_i;
      logic                w_sub_i;
      logic [c_SLICE_W:0]  w_sum;
      logic [c_DONE_W-1:0] w_res_o;

      if (s == 0) begin : g_first
         assign w_valid_i = in_valid;
         assign w_a_i     = in_a;
         assign w_b_i     = w_b_eff;
         assign w_cy_i    = w_cin0;
         assign w_sub_i   = w_sub;
         assign w_res_o   = w_sum[c_SLICE_W-1:0];
      end else begin : g_next
         assign w_valid_i = g_stage[s-1].g_mid.r_valid;
         assign w_a_i     = g_stage[s-1].g_mid.r_a;
         assign w_b_i     = g_stage[s-1].g_mid.r_b;
         assign w_cy_i    = g_stage[s-1].g_mid.r_cy;
         assign w_sub_i   = g_stage[s-1].g_mid.r_sub;
         assign w_res_o   = {w_sum[c_SLICE_W-1:0], g_stage[s-1].g_mid.r_res};
      end

      assign w_sum = {1'b0, w_a_i[c_SLICE_W-1:0]} + {1'b0, w_b_i[c_SLICE_W-1:0]}
                   + {{c_SLICE_W{1'b0}}, w_cy_i};

      if (s < STAGES - 1) begin : g_mid
         // Only the operand slices still to be consumed are skewed forward.
         logic                          r_valid;
         logic [c_REM_W-c_SLICE_W-1:0]  r_a;
         logic [c_REM_W-c_SLICE_W-1:0]  r_b;
         logic                          r_cy;
         logic                          r_sub;
         logic [c_DONE_W-1:0]           r_res;

         always_ff @(posedge clk) begin
            if (!reset) begin
               r_valid <= 1'b0;
               r_a     <= '0;
               r_b     <= '0;
               r_cy    <= 1'b0;
               r_sub   <= 1'b0;
               r_res   <= '0;
            end else if (w_advance) begin
               r_valid <= w_valid_i;
               r_a     <= w_a_i[c_REM_W-1:c_SLICE_W];
               r_b     <= w_b_i[c_REM_W-1:c_SLICE_W];
               r_cy    <= w_sum[c_SLICE_W];
               r_sub   <= w_sub_i;
               r_res   <= w_res_o;
            end
         end
      end else begin : g_last
         // Operand MSBs are in this slice; b is already inverted for subtraction.
         always_ff @(posedge clk) begin
            if (!reset) begin
               out_valid    <= 1'b0;
               out_result   <= '0;
               out_carry    <= 1'b0;
               out_overflow <= 1'b0;
               out_zero     <= 1'b0;
               out_negative <= 1'b0;
            end else if (w_advance) begin
               out_valid    <= w_valid_i;
               out_result   <= w_res_o;
               out_carry    <= w_sum[c_SLICE_W] ^ w_sub_i;
               out_overflow <= (w_a_i[c_SLICE_W-1] == w_b_i[c_SLICE_W-1]) &&
                               (w_sum[c_SLICE_W-1] != w_a_i[c_SLICE_W-1]);
               out_zero     <= (w_res_o == '0);
               out_negative <= w_sum[c_SLICE_W-1];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_arith_unit.sv
`default_nettype none
// =============================================================================
// tb_pipelined_arith_unit : directed 8-bit checks plus a randomized 16-bit sweep over STAGES=1,2,4
// Revision 1.0
// =============================================================================
module tb_pipelined_arith_unit;

   typedef struct packed {
      logic [15:0] res;
      logic        c;
      logic        v;
      logic        z;
      logic        n;
   } exp_t;

   localparam int c_N16    = 10000;
   localparam int c_BUDGET = 45000;

   logic clk;
   logic reset;

   // 8-bit, 2-stage instance
   logic       v8, ordy8, cin8;
   logic [7:0] a8, b8;
   logic [1:0] op8;
   wire        rdy8, ov8, c8, o8, z8, n8;
   wire  [7:0] res8;

   // 16-bit instances, index i has STAGES = 1 << i
   logic [2:0]  v16, ordy16, cin16;
   logic [15:0] a16 [3];
   logic [15:0] b16 [3];
   logic [1:0]  op16 [3];
   wire  [2:0]  rdy16, ov16, c16, o16, z16, n16;
   wire  [15:0] res16 [3];

   int checks = 0;
   int errors = 0;

   pipelined_arith_unit #(.WIDTH(8), .STAGES(2)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8),
      .in_op(op8), .in_cin(cin8), .out_valid(ov8), .out_ready(ordy8), .out_result(res8),
      .out_carry(c8), .out_overflow(o8), .out_zero(z8), .out_negative(n8)
   );

   for (genvar g = 0; g < 3; g++) begin : g_dut16
      pipelined_arith_unit #(.WIDTH(16), .STAGES(1 << g)) u_dut (
         .clk(clk), .reset(reset), .in_valid(v16[g]), .in_ready(rdy16[g]), .in_a(a16[g]),
         .in_b(b16[g]), .in_op(op16[g]), .in_cin(cin16[g]), .out_valid(ov16[g]),
         .out_ready(ordy16[g]), .out_result(res16[g]), .out_carry(c16[g]),
         .out_overflow(o16[g]), .out_zero(z16[g]), .out_negative(n16[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Arithmetic reference: unsigned/signed integer math, then reduce modulo 2^w.
   function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic [1:0] op, input logic cin);
      exp_t   m;
      longint ua, ub, ci, md, hf, sa, sb, u, s, r;
      md = longint'(1) << w;
      hf = md / 2;
      ua = longint'(a);
      ub = longint'(b);
      ci = (op[1] && cin) ? 1 : 0;
      sa = (ua >= hf) ? ua - md : ua;
      sb = (ub >= hf) ? ub - md : ub;
      if (op[0] == 1'b0) begin
         u   = ua + ub + ci;
         s   = sa + sb + ci;
         m.c = (u >= md);
      end else begin
         u   = ua - ub - ci;
         s   = sa - sb - ci;
         m.c = (ua < ub + ci);
      end
      r     = ((u % md) + md) % md;
      m.res = 16'(r);
      m.v   = (s < -hf) || (s >= hf);
      m.z   = (r == 0);
      m.n   = (r >= hf);
      return m;
   endfunction

   // Scoreboard for the 8-bit instance
   exp_t       f8 [16];
   int         h8 = 0, t8 = 0, got8 = 0;
   logic       pre_rdy, pre_acc, pre_cons, pre_ov, pre_c, pre_o, pre_z, pre_n;
   logic [7:0] pre_res;

   task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic cin, input logic ordy);
      exp_t e;
      @(negedge clk);
      v8 = v; a8 = a; b8 = b; op8 = op; cin8 = cin; ordy8 = ordy;
      #1;
      pre_rdy = rdy8; pre_acc = v & rdy8; pre_cons = ov8 & ordy; pre_ov = ov8;
      pre_res = res8; pre_c = c8; pre_o = o8; pre_z = z8; pre_n = n8;
      @(posedge clk);
      #1;
      if (pre_cons) begin
         if (h8 != t8) begin
            e = f8[h8 % 16];
            chk("o8_res", pre_res, e.res[7:0]);
            chk("o8_carry", pre_c, e.c);
            chk("o8_ovf", pre_o, e.v);
            chk("o8_zero", pre_z, e.z);
            chk("o8_neg", pre_n, e.n);
            h8++;
            got8++;
         end else begin
            chk("o8_unexpected_result", 1, 0);
         end
      end
      if (pre_acc) begin
         f8[t8 % 16] = model(8, {8'h00, a}, {8'h00, b}, op, cin);
         t8++;
      end
   endtask

   task automatic do_dir(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic cin, input logic [7:0] er,
                         input logic ec, input logic ev, input logic ez, input logic en);
      int edges;
      @(negedge clk);
      v8 = 1'b1; a8 = a; b8 = b; op8 = op; cin8 = cin; ordy8 = 1'b1;
      #1;
      chk({nm, "_in_ready"}, rdy8, 1);
      @(posedge clk);
      #1;
      v8 = 1'b0;
      edges = 1;
      while (!ov8 && edges < 8) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk({nm, "_latency"}, edges, 2);
      chk({nm, "_res"}, res8, er);
      chk({nm, "_carry"}, c8, ec);
      chk({nm, "_ovf"}, o8, ev);
      chk({nm, "_zero"}, z8, ez);
      chk({nm, "_neg"}, n8, en);
      @(posedge clk);
      #1;
      chk({nm, "_consumed"}, ov8, 0);
   endtask

   // Scoreboards for the 16-bit instances
   exp_t        f16 [3][16];
   int          adv0 [3][16];
   int          h16 [3], t16 [3], sent16 [3], got16 [3], advc [3];
   logic [2:0]  acc16, cons16, padv16, sc16, so16, sz16, sn16;
   logic [15:0] sr16 [3];

   logic [7:0] bpa [4];
   logic [7:0] bpb [4];
   logic [1:0] bpo [4];
   logic       bpc [4];
   exp_t       r0;
   int         k, idx, got_before, cyc;
   exp_t       e16;

   initial begin
      reset = 1'b0;
      v8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; cin8 = 1'b0; ordy8 = 1'b1;
      v16 = '0; ordy16 = '1; cin16 = '0;
      for (int i = 0; i < 3; i++) begin
         a16[i] = '0; b16[i] = '0; op16[i] = '0;
      end

      // ---- reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", ov8, 0);
      chk("rst_result", res8, 0);
      chk("rst_flags", {c8, o8, z8, n8}, 0);
      chk("rst_in_ready", rdy8, 1);
      chk("rst_out_valid16", ov16, 0);
      @(negedge clk);
      reset = 1'b1;

      // ---- directed arithmetic / flag cases
      do_dir("add_ff_01",  8'hFF, 8'h01, 2'b00, 1'b0, 8'h00, 1, 0, 1, 0);
      do_dir("add_7f_01",  8'h7F, 8'h01, 2'b00, 1'b0, 8'h80, 0, 1, 0, 1);
      do_dir("sub_80_01",  8'h80, 8'h01, 2'b01, 1'b0, 8'h7F, 0, 1, 0, 0);
      do_dir("sub_00_01",  8'h00, 8'h01, 2'b01, 1'b0, 8'hFF, 1, 0, 0, 1);
      do_dir("sbb_05_05",  8'h05, 8'h05, 2'b11, 1'b1, 8'hFF, 1, 0, 0, 1);
      do_dir("adc_0f_00",  8'h0F, 8'h00, 2'b10, 1'b1, 8'h10, 0, 0, 0, 0);
      do_dir("add_cin_ig", 8'h03, 8'h04, 2'b00, 1'b1, 8'h07, 0, 0, 0, 0);
      do_dir("sub_cin_ig", 8'h05, 8'h05, 2'b01, 1'b1, 8'h00, 0, 0, 1, 0);

      // ---- backpressure: 4 back-to-back requests, 3-cycle stall after the first result
      bpa[0] = 8'h10; bpb[0] = 8'h20; bpo[0] = 2'b00; bpc[0] = 1'b0;
      bpa[1] = 8'h50; bpb[1] = 8'h30; bpo[1] = 2'b01; bpc[1] = 1'b0;
      bpa[2] = 8'hF0; bpb[2] = 8'h20; bpo[2] = 2'b10; bpc[2] = 1'b1;
      bpa[3] = 8'h01; bpb[3] = 8'h02; bpo[3] = 2'b11; bpc[3] = 1'b1;
      r0 = model(8, {8'h00, bpa[0]}, {8'h00, bpb[0]}, bpo[0], bpc[0]);
      got_before = got8;
      k = 0;
      idx = 0;
      while ((idx < 4 || h8 != t8) && k < 30) begin
         step8(idx < 4, bpa[idx % 4], bpb[idx % 4], bpo[idx % 4], bpc[idx % 4], !(k >= 2 && k <= 4));
         if (k >= 2 && k <= 4) begin
            chk("bp_in_ready_stall", pre_rdy, 0);
            chk("bp_hold_valid", pre_ov, 1);
            chk("bp_hold_res", pre_res, r0.res[7:0]);
            chk("bp_hold_flags", {pre_c, pre_o, pre_z, pre_n}, {r0.c, r0.v, r0.z, r0.n});
         end
         if (pre_acc) idx++;
         k++;
      end
      chk("bp_results_count", got8 - got_before, 4);

      // ---- reset while two requests are in flight, with a request offered on the reset edge
      step8(1'b1, 8'h11, 8'h22, 2'b00, 1'b0, 1'b1);
      step8(1'b1, 8'h33, 8'h44, 2'b01, 1'b0, 1'b1);
      @(negedge clk);
      reset = 1'b0; v8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; op8 = 2'b00; ordy8 = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_out_valid", ov8, 0);
      chk("mid_rst_result", res8, 0);
      chk("mid_rst_flags", {c8, o8, z8, n8}, 0);
      chk("mid_rst_in_ready", rdy8, 1);
      h8 = t8;
      @(negedge clk);
      reset = 1'b1; v8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step8(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
         chk("post_rst_idle_valid", pre_ov, 0);
      end
      got_before = got8;
      step8(1'b1, 8'h12, 8'h34, 2'b00, 1'b0, 1'b1);
      k = 0;
      while (h8 != t8 && k < 10) begin
         step8(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
         k++;
      end
      chk("post_rst_results_count", got8 - got_before, 1);

      // ---- randomized 16-bit sweep, STAGES = 1, 2, 4
      for (int i = 0; i < 3; i++) begin
         h16[i] = 0; t16[i] = 0; sent16[i] = 0; got16[i] = 0; advc[i] = 0;
      end
      acc16 = '0;
      cyc = 0;
      while ((got16[0] < c_N16 || got16[1] < c_N16 || got16[2] < c_N16) && cyc < c_BUDGET) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (!v16[i] || acc16[i]) begin
               if (sent16[i] < c_N16 && $urandom_range(0, 3) != 0) begin
                  v16[i]   = 1'b1;
                  a16[i]   = 16'($urandom);
                  b16[i]   = 16'($urandom);
                  op16[i]  = 2'($urandom_range(0, 3));
                  cin16[i] = 1'($urandom_range(0, 1));
               end else begin
                  v16[i] = 1'b0;
               end
            end
            ordy16[i] = ($urandom_range(0, 3) != 0);
         end
         #1;
         for (int i = 0; i < 3; i++) begin
            acc16[i]  = v16[i] & rdy16[i];
            cons16[i] = ov16[i] & ordy16[i];
            padv16[i] = rdy16[i];
            sr16[i]   = res16[i];
            sc16[i] = c16[i]; so16[i] = o16[i]; sz16[i] = z16[i]; sn16[i] = n16[i];
         end
         @(posedge clk);
         #1;
         cyc++;
         for (int i = 0; i < 3; i++) begin
            if (padv16[i]) advc[i]++;
            if (cons16[i]) begin
               if (h16[i] != t16[i]) begin
                  e16 = f16[i][h16[i] % 16];
                  chk($sformatf("s%0d_res", 1 << i), sr16[i], e16.res);
                  chk($sformatf("s%0d_carry", 1 << i), sc16[i], e16.c);
                  chk($sformatf("s%0d_ovf", 1 << i), so16[i], e16.v);
                  chk($sformatf("s%0d_zero", 1 << i), sz16[i], e16.z);
                  chk($sformatf("s%0d_neg", 1 << i), sn16[i], e16.n);
                  h16[i]++;
                  got16[i]++;
               end else begin
                  chk($sformatf("s%0d_unexpected_result", 1 << i), 1, 0);
               end
            end
            if (acc16[i]) begin
               f16[i][t16[i] % 16]  = model(16, a16[i], b16[i], op16[i], cin16[i]);
               adv0[i][t16[i] % 16] = advc[i];
               t16[i]++;
               sent16[i]++;
            end
            // A newly presented result has travelled exactly STAGES advancing edges.
            if (padv16[i] && ov16[i]) begin
               if (h16[i] != t16[i])
                  chk($sformatf("s%0d_latency", 1 << i), advc[i] - adv0[i][h16[i] % 16] + 1, 1 << i);
               else
                  chk($sformatf("s%0d_spurious_valid", 1 << i), 1, 0);
            end
         end
      end
      chk("sweep_within_budget", (cyc < c_BUDGET), 1);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("s%0d_results_count", 1 << i), got16[i], c_N16);
         chk($sformatf("s%0d_none_pending", 1 << i), t16[i] - h16[i], 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
